mix_columns_seq: RTL and testbench
==================================

Name: mix_columns_seq

Overview:
- Sequential, parametrised successor to the combinational AES MixColumns stage.
- Processes a 128-bit AES state in 4/COLS_PER_CYCLE cycles, using COLS_PER_CYCLE column datapaths.
- Supports forward (encrypt) and inverse (decrypt) MixColumns, selected per block.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round datapath, with valid/ready handshakes on both sides.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per cycle; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input block valid
- in_ready  out  1  block accepted when in_valid && in_ready
- inv  in  1  0 = forward matrix {02,03,01,01}; 1 = inverse matrix {0e,0b,0d,09}; sampled on accept
- data_in  in  128  state; column c = data_in[127-32c -: 32], row r byte = [127-32c-8r -: 8]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- data_out  out  128  transformed state, same byte ordering

Behaviour:
- GF(2^8) arithmetic uses polynomial 0x11B.
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 0).
  - Multiplies by 03/09/0b/0d/0e are built from xtime chains and XOR; no lookup tables.
- Forward, per column a0..a3: out_r = 02*a_r ^ 03*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
- Inverse: out_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3).
- State register holds the block; a column counter col_idx (2 bits) steps by COLS_PER_CYCLE.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On accept: latch data_in and inv, col_idx=0, go to BUSY.
  - BUSY: each cycle, columns col_idx .. col_idx+COLS_PER_CYCLE-1 are replaced in place with their transform, and col_idx advances. After the last group, go to DONE. in_ready=0.
  - DONE: out_valid=1, data_out = state register, held stable until out_ready.
    - On out_ready with no new accept: go to IDLE.
    - in_ready = out_ready in DONE, so a new block can be accepted in the same cycle as the output handshake (BUSY next). This gives back-to-back throughput of one block per 4/COLS_PER_CYCLE+1 cycles.
- Latency from accept to out_valid: 4/COLS_PER_CYCLE + 1 cycles (COLS_PER_CYCLE=4: 2 cycles).
- inv and data_in changes while BUSY or DONE have no effect.
- Reset (async, any state, including mid-BUSY): state=IDLE, out_valid=0, data_out=0, col_idx=0, latched inv=0, partial result discarded; in_ready=1 one cycle after deassertion.
- data_out equals the state register. It reads 0 from reset until the first block reaches DONE. After a block leaves DONE it keeps showing that completed result while in IDLE and shows partial results while a new block is in BUSY. It must be used only when out_valid=1.

Optional Feature:
- MIXCOL_BYPASS_EN.
  - Defined: adds input port bypass (1 bit), sampled on accept with inv. When set, the block skips the transform: BUSY lasts one cycle with state unchanged, then DONE. data_out equals data_in; latency is 2 cycles regardless of COLS_PER_CYCLE. Used for the final AES round.
  - Undefined: no bypass port; every block is transformed.

Test Plan:
- Forward, COLS_PER_CYCLE=1, data_in=d4bf5d30e0b452aeb84111f11e2798e5 -> data_out=046681e5e0cb199a48f8d37a2806264c, out_valid exactly 5 cycles after accept.
- Inverse, all COLS_PER_CYCLE values, data_in=046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5; latency 5/3/2 cycles.
- Known columns, forward: db135345 f20a225c 01010101 c6c6c6c6 -> 8e4da1bc 9fdc589d 01010101 c6c6c6c6. Inverse of that result returns the original input.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> data_out stable, in_ready=0. Then raise out_ready together with in_valid carrying a new block -> same-cycle accept, next result correct.
- Reset mid-BUSY, after 2 columns with COLS_PER_CYCLE=1 -> out_valid=0, data_out=0, in_ready=1 after release. Next block gives the correct result with no stale columns.
- With MIXCOL_BYPASS_EN: bypass=1, data_in=00112233445566778899aabbccddeeff -> identical data_out after 2 cycles. bypass=0 on the next block transforms normally.

Source files
------------

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq: input block channel and output result channel.
// When MIXCOL_BYPASS_EN is defined the input channel also carries the bypass flag.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         inv;
  logic [127:0] data_in;
`ifdef MIXCOL_BYPASS_EN
  logic         bypass;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  // Design side
  modport slave (
`ifdef MIXCOL_BYPASS_EN
    input  bypass,
`endif
    input  in_valid,
    input  inv,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out
  );

  // Driver side
  modport master (
`ifdef MIXCOL_BYPASS_EN
    output bypass,
`endif
    output in_valid,
    output inv,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns stage.
// Transforms COLS_PER_CYCLE columns per cycle in place inside the state register,
// so a block takes 4/COLS_PER_CYCLE BUSY cycles followed by one DONE cycle.
// Optional feature macro: MIXCOL_BYPASS_EN (adds a per-block bypass for the final round).
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst_n,
  mix_columns_seq_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Step of 4 wraps to 0 in two bits, which is exactly what COLS_PER_CYCLE=4 needs.
  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastIdx = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [1:0]   col_idx_q, col_idx_d;
  logic         inv_q, inv_d;
  logic         out_valid_q, out_valid_d;
  logic         accept;
  logic         in_ready;
  logic         skip;

  // Multiply by 02 in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse matrix; row 0 is the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_sel);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    int          r1, r2, r3;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      r1 = (r + 1) % 4;
      r2 = (r + 2) % 4;
      r3 = (r + 3) % 4;
      if (!inv_sel) begin
        // 02*a_r ^ 03*a_r1 ^ a_r2 ^ a_r3
        res[31-8*r -: 8] = x2[r] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
      end else begin
        // 0e*a_r ^ 0b*a_r1 ^ 0d*a_r2 ^ 09*a_r3
        res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                         ^ (x8[r1] ^ x2[r1] ^ a[r1])
                         ^ (x8[r2] ^ x4[r2] ^ a[r2])
                         ^ (x8[r3] ^ a[r3]);
      end
    end
    return res;
  endfunction

`ifdef MIXCOL_BYPASS_EN
  logic byp_q, byp_d;
  assign skip = byp_q;
`else
  assign skip = 1'b0;
`endif

  // DONE hands in_ready straight through from out_ready so a new block can overlap the output.
  assign in_ready      = (st_q == StIdle) || ((st_q == StDone) && bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = state_q;

  // Next-state: FSM sequencing, block load, and in-place column group transform.
  always_comb begin
    logic [1:0] idx;
    int         base;
    st_d      = st_q;
    state_d   = state_q;
    col_idx_d = col_idx_q;
    inv_d     = inv_q;
`ifdef MIXCOL_BYPASS_EN
    byp_d     = byp_q;
`endif
    idx       = '0;
    base      = 0;

    unique case (st_q)
      StIdle, StDone: begin
        if (accept) begin
          st_d      = StBusy;
          state_d   = bus.data_in;
          inv_d     = bus.inv;
          col_idx_d = '0;
`ifdef MIXCOL_BYPASS_EN
          byp_d     = bus.bypass;
`endif
        end else if (st_q == StDone && bus.out_ready) begin
          st_d = StIdle;
        end
      end
      StBusy: begin
        if (skip) begin
          st_d = StDone;
        end else begin
          for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
            idx  = col_idx_q + 2'(g);
            base = 127 - 32 * int'(idx);
            state_d[base -: 32] = mix_col(state_q[base -: 32], inv_q);
          end
          col_idx_d = col_idx_q + ColStep;
          if (col_idx_q == LastIdx) begin
            st_d = StDone;
          end
        end
      end
      default: st_d = StIdle;
    endcase

    out_valid_d = (st_d == StDone);
  end

  // State register; reset discards any partial block and clears the visible result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      state_q     <= '0;
      col_idx_q   <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef MIXCOL_BYPASS_EN
      byp_q       <= 1'b0;
`endif
    end else begin
      st_q        <= st_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
`ifdef MIXCOL_BYPASS_EN
      byp_q       <= byp_d;
`endif
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) driven from a
// shared vector table, plus directed backpressure, reset and (optional) bypass sequences.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid_a  [3];
  logic         inv_a       [3];
  logic [127:0] data_in_a   [3];
  logic         out_ready_a [3];
  logic         bypass_a    [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic [127:0] data_out_w  [3];

  mix_columns_seq_if bus_if [3] ();

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign bus_if[k].in_valid  = in_valid_a[k];
    assign bus_if[k].inv       = inv_a[k];
    assign bus_if[k].data_in   = data_in_a[k];
    assign bus_if[k].out_ready = out_ready_a[k];
`ifdef MIXCOL_BYPASS_EN
    assign bus_if[k].bypass    = bypass_a[k];
`endif
    assign in_ready_w[k]       = bus_if[k].in_ready;
    assign out_valid_w[k]      = bus_if[k].out_valid;
    assign data_out_w[k]       = bus_if[k].data_out;

    mix_columns_seq #(.COLS_PER_CYCLE(1 << k)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if[k])
    );
  end

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Drive one block into instance k; lat counts the accept cycle as 1.
  task automatic run_block(input int k, input logic inv, input logic [127:0] d,
                           input logic byp, output logic [127:0] res, output int lat);
    int guard;
    inv_a[k]       = inv;
    data_in_a[k]   = d;
    bypass_a[k]    = byp;
    in_valid_a[k]  = 1'b1;
    out_ready_a[k] = 1'b1;
    #1;
    guard = 0;
    while (!in_ready_w[k] && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!in_ready_w[k]) begin
      n_checks++;
      $display("FAIL accept_timeout inst %0d: in_ready got 0 required 1", k);
    end
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    // Inputs changing after accept must not leak into the block.
    inv_a[k]     = ~inv;
    data_in_a[k] = ~d;
    bypass_a[k]  = ~byp;
    lat = 1;
    while (!out_valid_w[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = data_out_w[k];
    // Complete the output handshake (out_ready is high).
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] VA = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] VB = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] VC = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] VD = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] VE = 128'hffffffff01010101000000005a5a5a5a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] res;
    logic [127:0] held;
    int           lat;

    vecs[0] = '{inv: 1'b0, din: VA, exp: VB};
    vecs[1] = '{inv: 1'b1, din: VB, exp: VA};
    vecs[2] = '{inv: 1'b0, din: VC, exp: VD};
    vecs[3] = '{inv: 1'b1, din: VD, exp: VC};
    vecs[4] = '{inv: 1'b0, din: '0, exp: '0};
    vecs[5] = '{inv: 1'b1, din: VE, exp: VE};

    for (int k = 0; k < 3; k++) begin
      in_valid_a[k]  = 1'b0;
      inv_a[k]       = 1'b0;
      data_in_a[k]   = '0;
      out_ready_a[k] = 1'b1;
      bypass_a[k]    = 1'b0;
    end

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_in_ready_%0d", k), 128'(in_ready_w[k]), 128'd1);
      check($sformatf("reset_out_valid_%0d", k), 128'(out_valid_w[k]), 128'd0);
      check($sformatf("reset_data_out_%0d", k), data_out_w[k], '0);
    end

    // Vector table on every datapath width.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        run_block(k, vecs[i].inv, vecs[i].din, 1'b0, res, lat);
        check($sformatf("vec%0d_data_c%0d", i, 1 << k), res, vecs[i].exp);
        check($sformatf("vec%0d_lat_c%0d", i, 1 << k), 128'(lat), 128'((4 >> k) + 1));
      end
    end

    // Backpressure on the 1-column instance.
    out_ready_a[0] = 1'b0;
    inv_a[0]       = 1'b0;
    data_in_a[0]   = VC;
    in_valid_a[0]  = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    lat = 1;
    while (!out_valid_w[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 128'(lat), 128'd5);
    held = data_out_w[0];
    check("bp_first_data", held, VD);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_data_%0d", c), data_out_w[0], VD);
      check($sformatf("bp_hold_ctl_%0d", c), 128'({out_valid_w[0], in_ready_w[0]}), 128'b10);
    end
    out_ready_a[0] = 1'b1;
    inv_a[0]       = 1'b1;
    data_in_a[0]   = VD;
    in_valid_a[0]  = 1'b1;
    #1;
    check("bp_same_cycle_ready", 128'(in_ready_w[0]), 128'd1);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    check("bp_accepted_busy", 128'(out_valid_w[0]), 128'd0);
    lat = 1;
    while (!out_valid_w[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_lat", 128'(lat), 128'd5);
    check("bp_next_data", data_out_w[0], VC);
    @(posedge clk); #1;

    // Reset in the middle of BUSY after two columns.
    inv_a[0]      = 1'b0;
    data_in_a[0]  = VA;
    in_valid_a[0] = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("rst_data_out", data_out_w[0], '0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 128'(in_ready_w[0]), 128'd1);
    check("rst_idle_data", data_out_w[0], '0);
    run_block(0, 1'b1, VB, 1'b0, res, lat);
    check("rst_next_data", res, VA);
    check("rst_next_lat", 128'(lat), 128'd5);

`ifdef MIXCOL_BYPASS_EN
    for (int k = 0; k < 3; k++) begin
      run_block(k, 1'b0, 128'h00112233445566778899aabbccddeeff, 1'b1, res, lat);
      check($sformatf("byp_data_c%0d", 1 << k), res, 128'h00112233445566778899aabbccddeeff);
      check($sformatf("byp_lat_c%0d", 1 << k), 128'(lat), 128'd2);
      run_block(k, 1'b0, VA, 1'b0, res, lat);
      check($sformatf("byp_off_data_c%0d", 1 << k), res, VB);
      check($sformatf("byp_off_lat_c%0d", 1 << k), 128'(lat), 128'((4 >> k) + 1));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
